// File: rtl/dmi_jtag_ctrl_if.sv
// DMI request/response channel between the DTM controller (master) and the
// Debug Module (slave).
interface dmi_jtag_ctrl_if #(
   parameter int unsigned AbitsWidth = 7
) ();
   logic                  req_valid;
   logic                  req_ready;
   logic [AbitsWidth-1:0] req_addr;
   logic [1:0]            req_op;
   logic [31:0]           req_data;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [31:0]           resp_data;
   logic [1:0]            resp_resp;

   modport master (
      output req_valid, req_addr, req_op, req_data, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_resp
   );

   modport slave (
      input  req_valid, req_addr, req_op, req_data, resp_ready,
      output req_ready, resp_valid, resp_data, resp_resp
   );
endinterface

// File: rtl/dmi_jtag_ctrl.sv
// DTM-side JTAG controller: DTMCS/DMI data registers, DMI request sequencing and
// sticky busy/failed status. Optional request timeout: define DMI_TIMEOUT_EN.
module dmi_jtag_ctrl #(
   parameter int unsigned AbitsWidth    = 7,
   parameter int unsigned IdleCycles    = 1,
   parameter int unsigned Version       = 1,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic            tck_i,
   input  logic            trst_ni,
   input  logic            dmi_clear_i,
   input  logic            capture_i,
   input  logic            shift_i,
   input  logic            update_i,
   input  logic            tdi_i,
   input  logic            dtmcs_select_i,
   output logic            dtmcs_tdo_o,
   input  logic            dmi_select_i,
   output logic            dmi_tdo_o,
   output logic            dmi_rst_no,
   dmi_jtag_ctrl_if.master dmi
);
   localparam int unsigned DrW = AbitsWidth + 34;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_e;

   state_e                state_q;
   logic [31:0]           dtmcs_q;
   logic [DrW-1:0]        dmi_sr_q;
   logic [AbitsWidth-1:0] addr_q;
   logic [31:0]           data_q;
   logic [1:0]            op_q, err_q;
   logic                  req_valid_q, resp_ready_q, rst_n_q;

   logic        busy, dtmcs_upd, dmi_upd, dmi_cap, dmireset, hardreset, timeout;
   logic [1:0]  cap_op_d;
   logic [31:0] dtmcs_cap_d;

   assign busy      = (state_q != IDLE);
   assign dtmcs_upd = update_i & dtmcs_select_i;
   assign dmi_upd   = update_i & dmi_select_i;
   assign dmi_cap   = capture_i & dmi_select_i;
   assign dmireset  = dtmcs_upd & dtmcs_q[16];
   assign hardreset = dtmcs_upd & dtmcs_q[17];
   assign cap_op_d  = busy ? 2'd3 : err_q;

   assign dtmcs_cap_d = {14'd0, 1'b0, 1'b0, 1'b0, 3'(IdleCycles), err_q,
                         6'(AbitsWidth), 4'(Version)};

`ifdef DMI_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
   logic [CntW-1:0] cnt_q;

   // Restarts on every state entry so REQ and WAIT_RSP each get the full budget.
   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         cnt_q <= '0;
      end else if (dmi_clear_i || !busy || hardreset || timeout ||
                   (state_q == REQ && dmi.req_ready)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign timeout = busy && (cnt_q == CntW'(TimeoutCycles - 1));
`else
   logic unused_timeout;
   assign unused_timeout = ^32'(TimeoutCycles);
   assign timeout        = 1'b0;
`endif

   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         dtmcs_q  <= '0;
         dmi_sr_q <= '0;
      end else if (dmi_clear_i) begin
         dtmcs_q  <= '0;
         dmi_sr_q <= '0;
      end else begin
         if (dtmcs_select_i) begin
            if (capture_i)    dtmcs_q <= dtmcs_cap_d;
            else if (shift_i) dtmcs_q <= {tdi_i, dtmcs_q[31:1]};
         end
         if (dmi_select_i) begin
            if (capture_i)    dmi_sr_q <= {addr_q, data_q, cap_op_d};
            else if (shift_i) dmi_sr_q <= {tdi_i, dmi_sr_q[DrW-1:1]};
         end
      end
   end

   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         state_q      <= IDLE;
         req_valid_q  <= 1'b0;
         resp_ready_q <= 1'b0;
         rst_n_q      <= 1'b1;
         addr_q       <= '0;
         data_q       <= '0;
         op_q         <= '0;
         err_q        <= '0;
      end else if (dmi_clear_i) begin
         state_q      <= IDLE;
         req_valid_q  <= 1'b0;
         resp_ready_q <= 1'b0;
         rst_n_q      <= 1'b1;
         addr_q       <= '0;
         data_q       <= '0;
         op_q         <= '0;
         err_q        <= '0;
      end else begin
         rst_n_q <= ~hardreset;

         unique case (state_q)
            IDLE: begin
               if (dmi_upd && err_q == 2'd0 &&
                   (dmi_sr_q[1:0] == 2'd1 || dmi_sr_q[1:0] == 2'd2)) begin
                  state_q     <= REQ;
                  req_valid_q <= 1'b1;
               end
            end
            REQ: begin
               if (dmi.req_ready) begin
                  state_q      <= WAIT_RSP;
                  req_valid_q  <= 1'b0;
                  resp_ready_q <= 1'b1;
               end else if (timeout) begin
                  state_q     <= IDLE;
                  req_valid_q <= 1'b0;
                  if (err_q == 2'd0) err_q <= 2'd2;
               end
            end
            WAIT_RSP: begin
               if (dmi.resp_valid) begin
                  state_q      <= IDLE;
                  resp_ready_q <= 1'b0;
                  if (op_q == 2'd1) data_q <= dmi.resp_data;
                  if (dmi.resp_resp == 2'd2 && err_q == 2'd0) err_q <= 2'd2;
               end else if (timeout) begin
                  state_q      <= IDLE;
                  resp_ready_q <= 1'b0;
                  if (err_q == 2'd0) err_q <= 2'd2;
               end
            end
            default: begin
               state_q      <= IDLE;
               req_valid_q  <= 1'b0;
               resp_ready_q <= 1'b0;
            end
         endcase

         // Busy detection follows the FSM block so it outranks a same-cycle response error.
         if (dmi_upd && err_q == 2'd0) begin
            if (busy) begin
               err_q <= 2'd3;
            end else begin
               addr_q <= dmi_sr_q[DrW-1:34];
               data_q <= dmi_sr_q[33:2];
               op_q   <= dmi_sr_q[1:0];
            end
         end
         if (dmi_cap && busy && err_q == 2'd0) err_q <= 2'd3;

         if (hardreset) begin
            state_q      <= IDLE;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
         end
         if (dmireset || hardreset) err_q <= 2'd0;
      end
   end

   assign dtmcs_tdo_o    = dtmcs_q[0];
   assign dmi_tdo_o      = dmi_sr_q[0];
   assign dmi_rst_no     = rst_n_q;
   assign dmi.req_valid  = req_valid_q;
   assign dmi.req_addr   = addr_q;
   assign dmi.req_op     = op_q;
   assign dmi.req_data   = data_q;
   assign dmi.resp_ready = resp_ready_q;
endmodule
